// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding and default timing constants for the UART transmit scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE, SEND, FRAME, GAP} state_e;
  localparam int DIV_DEFAULT = 326;
  localparam int FRAME_TICKS_DEFAULT = 160;
  localparam int SEND_HOLD_DEFAULT = 2;
  localparam int GAP_TICKS_DEFAULT = 16;
endpackage

// File: rtl/uart_tx_scheduler_tick_divider.sv
// tick_divider: free-running divider producing a single-cycle 16x tick every DIV clocks
module tick_divider
  import uart_sched_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic SystemClock,
  input  logic Reset,
  output logic Tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign Tick = cnt_q == TERM;
  always_comb cnt_d = Tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge SystemClock) cnt_q <= Reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one RS232 transmitter, pacing each grant by a frame plus gap
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV = DIV_DEFAULT,
  parameter int SEND_HOLD = SEND_HOLD_DEFAULT,
  parameter int FRAME_TICKS = FRAME_TICKS_DEFAULT,
  parameter int GAP_TICKS = GAP_TICKS_DEFAULT
) (
  input  logic               SystemClock,
  input  logic               Reset,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] ReqData,
  output logic [N_REQ-1:0]   Grant,
  output logic [7:0]         TxData,
  output logic               TxSend,
  output logic               Busy,
  output logic               Tick
);
  localparam int TMAX_A = SEND_HOLD > FRAME_TICKS ? SEND_HOLD : FRAME_TICKS;
  localparam int TMAX = TMAX_A > GAP_TICKS ? TMAX_A : GAP_TICKS;
  localparam int TW = $clog2(TMAX + 1);
  localparam int LW = $clog2(N_REQ);
  localparam logic [TW-1:0] SH = TW'(SEND_HOLD);
  localparam logic [TW-1:0] FT = TW'(FRAME_TICKS);
  localparam logic [TW-1:0] GT = TW'(GAP_TICKS);
  localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);
  state_e state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [LW-1:0] last_q, last_d, win;
  logic found;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_send_q, tx_send_d;
  tick_divider #(.DIV(DIV)) u_div (
    .SystemClock(SystemClock),
    .Reset(Reset),
    .Tick(Tick)
  );
  assign tcnt_inc = tcnt_q + 1'b1;
  // Scan farthest-first so the nearest requester after last overwrites earlier hits.
  always_comb begin
    win = last_q;
    found = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (Req[(int'(last_q) + i) % N_REQ]) begin
        win = LW'((int'(last_q) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    tcnt_d = Tick ? tcnt_inc : tcnt_q;
    last_d = last_q;
    grant_d = '0;
    tx_data_d = tx_data_q;
    tx_send_d = tx_send_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (found) begin
          state_d = SEND;
          last_d = win;
          grant_d = N_REQ'(1) << win;
          tx_data_d = ReqData[{win, 3'b000} +: 8];
          tx_send_d = 1'b1;
        end
      end
      SEND: if (Tick && tcnt_inc == SH) begin
        state_d = FRAME;
        tcnt_d = '0;
        tx_send_d = 1'b0;
      end
      FRAME: if (Tick && tcnt_inc == FT) begin
        state_d = GAP_TICKS == 0 ? IDLE : GAP;
        tcnt_d = '0;
      end
      default: if (Tick && tcnt_inc == GT) begin
        state_d = IDLE;
        tcnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      state_q <= IDLE;
      tcnt_q <= '0;
      last_q <= LAST_RST;
      grant_q <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      last_q <= last_d;
      grant_q <= grant_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
    end
  end
  // Reset masks the strobe combinationally so the transmitter never sees a stale Send.
  assign TxSend = tx_send_q & ~Reset;
  assign Grant = grant_q;
  assign TxData = tx_data_q;
  assign Busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios for arbitration, pacing and reset of uart_tx_scheduler
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
  logic [3:0] grant;
  logic [7:0] tx_data;
  logic tx_send, busy, tick;
  int checks = 0;
  int errors = 0;
  uart_tx_scheduler #(
    .N_REQ(4), .DIV(4), .SEND_HOLD(2), .FRAME_TICKS(10), .GAP_TICKS(2)
  ) dut (
    .SystemClock(clk),
    .Reset(rst),
    .Req(req),
    .ReqData(req_data),
    .Grant(grant),
    .TxData(tx_data),
    .TxSend(tx_send),
    .Busy(busy),
    .Tick(tick)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction
  task automatic wait_idle;
    int n = 0;
    while (busy && n < 300) begin
      step;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask
  task automatic wait_grant(output logic [3:0] g);
    int n = 0;
    step;
    while (grant === 4'b0 && n < 300) begin
      step;
      n++;
    end
    g = grant;
    checks++;
    if (grant === 4'b0) begin
      errors++;
      $display("FAIL wait_grant: no grant within %0d cycles, required one", n);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    repeat (3) begin
      step;
      checks++;
      if ({grant, tx_send, tx_data, busy, tick} !== 15'b0) begin
        errors++;
        $display("FAIL reset_outputs: grant=%b send=%b data=%h busy=%b tick=%b, required all 0",
                 grant, tx_send, tx_data, busy, tick);
      end
    end
    rst = 1'b0;
    step;
    checks++;
    if (grant !== 4'b0001 || tx_data !== 8'h11 || tx_send !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b data=%h send=%b busy=%b, required 0001 11 1 1",
               grant, tx_data, tx_send, busy);
    end
    req = 4'b0;
    wait_idle;
  endtask
  task automatic test_single;
    int gcnt, txc, bc, tc, n;
    req = 4'b0100;
    step;
    checks++;
    if (grant !== 4'b0100 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_grant: grant=%b data=%h, required 0100 a5", grant, tx_data);
    end
    req = 4'b0;
    gcnt = 1;
    txc = int'(tx_send);
    bc = 1;
    tc = int'(tick);
    n = 0;
    while (n < 300) begin
      step;
      n++;
      if (!busy) break;
      bc++;
      txc += int'(tx_send);
      tc += int'(tick);
      gcnt += int'(grant != 4'b0);
    end
    checks++;
    if (gcnt != 1) begin
      errors++;
      $display("FAIL single_grant_width: %0d grant cycles, required 1", gcnt);
    end
    checks++;
    if (txc < 5 || txc > 8) begin
      errors++;
      $display("FAIL single_send_high: %0d cycles, required 5..8", txc);
    end
    checks++;
    if (tc != 14) begin
      errors++;
      $display("FAIL single_busy_ticks: %0d ticks, required 14", tc);
    end
    checks++;
    if (bc < 53 || bc > 56) begin
      errors++;
      $display("FAIL single_busy_cycles: %0d cycles, required 53..56", bc);
    end
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_after: busy=%b data=%h, required 0 a5", busy, tx_data);
    end
  endtask
  task automatic test_round_robin;
    int got[5];
    int k = 0, n = 0, since = 0, tks = 0;
    req = 4'b0;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    req = 4'b1111;
    while (k < 5 && n < 600) begin
      step;
      n++;
      if (grant != 4'b0) begin
        if (k > 0) begin
          checks++;
          if (since < 54 || since > 57 || tks < 14) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: %0d cycles %0d ticks, required 54..57 cycles >=14 ticks",
                     k, since, tks);
          end
        end
        got[k] = idx_of(grant);
        k++;
        since = 0;
        tks = 0;
      end
      since++;
      tks += int'(tick);
    end
    req = 4'b0;
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL rr_count: %0d grants, required 5", k);
    end
    for (int j = 0; j < k; j++) begin
      checks++;
      if (got[j] != j % 4) begin
        errors++;
        $display("FAIL rr_order[%0d]: requester %0d, required %0d", j, got[j], j % 4);
      end
    end
    wait_idle;
  endtask
  task automatic test_late_request;
    logic [3:0] g;
    req = 4'b0001;
    step;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL late_first: grant=%b, required 0001", grant);
    end
    repeat (20) step;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL late_busy: busy=%b, required 1", busy);
    end
    req = 4'b1001;
    wait_grant(g);
    checks++;
    if (g !== 4'b1000) begin
      errors++;
      $display("FAIL late_second: grant=%b, required 1000", g);
    end
    req = 4'b0001;
    wait_grant(g);
    checks++;
    if (g !== 4'b0001) begin
      errors++;
      $display("FAIL late_third: grant=%b, required 0001", g);
    end
    req = 4'b0;
    wait_idle;
  endtask
  task automatic test_withdrawn;
    int g1 = 0, rises = 0;
    logic prev;
    req = 4'b0100;
    step;
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL wd_grant: grant=%b, required 0100", grant);
    end
    req = 4'b0;
    prev = tx_send;
    for (int j = 0; j < 100; j++) begin
      if (j == 10) req = 4'b0010;
      if (j == 30) req = 4'b0;
      step;
      g1 += int'(grant[1]);
      rises += int'(tx_send & ~prev);
      prev = tx_send;
    end
    checks++;
    if (g1 != 0 || rises != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_no_send: grant1=%0d extra_sends=%0d busy=%b, required 0 0 0", g1, rises, busy);
    end
  endtask
  task automatic test_reset_mid_frame;
    int tk, n;
    req = 4'b0001;
    step;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL mid_grant: grant=%b, required 0001", grant);
    end
    req = 4'b0;
    tk = int'(tick);
    n = 0;
    while (tk < 7 && n < 200) begin
      step;
      n++;
      tk += int'(tick);
    end
    checks++;
    if (busy !== 1'b1 || tx_send !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_frame: busy=%b send=%b, required 1 0", busy, tx_send);
    end
    rst = 1'b1;
    step;
    checks++;
    if (tx_send !== 1'b0 || busy !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset: send=%b busy=%b grant=%b, required 0 0 0000", tx_send, busy, grant);
    end
    req = 4'b0010;
    rst = 1'b0;
    step;
    checks++;
    if (grant !== 4'b0010 || tx_data !== 8'h22 || tx_send !== 1'b1) begin
      errors++;
      $display("FAIL mid_regrant: grant=%b data=%h send=%b, required 0010 22 1", grant, tx_data, tx_send);
    end
    req = 4'b0;
    wait_idle;
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_late_request;
    test_withdrawn;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single RS232 transmitter between up to N_REQ byte requesters and sequences each transmission. Round-robin arbitration picks a requester, latches its byte onto the transmitter `DataIn`, and holds `Send` long enough for the 16x-clock domain to sample it. Further grants are blocked for a full frame plus an inter-frame gap. It sits between the application sources and the RS232 transmit path, alongside the existing 16x divider.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- DIV, default 326: SystemClock cycles per 16x tick. Matches the existing 16x divider terminal count of 325, plus 1.
- SEND_HOLD, default 2: 16x ticks `TxSend` is held high.
- FRAME_TICKS, default 160: 16x ticks in one frame (10 bits × 16).
- GAP_TICKS, default 16: idle 16x ticks after each frame; 0 is legal.
- SystemClock  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  N_REQ  per-requester request level.
- ReqData  in  8*N_REQ  byte for requester i, at [8i+7:8i].
- Grant  out  N_REQ  one-hot, single-cycle acknowledge.
- TxData  out  8  byte to the transmitter `DataIn`.
- TxSend  out  1  transmitter `Send` strobe.
- Busy  out  1  high whenever state ≠ IDLE.
- Tick  out  1  single-cycle 16x tick, also exported for debug.

## Operation
- Tick divider:
  - Counter runs 0..DIV-1 and is free-running. `Tick`=1 in the cycle the counter equals DIV-1, then the counter wraps to 0.
  - Reset clears the counter.
- States are IDLE, SEND, FRAME and GAP. A tick counter `tcnt` advances only on `Tick` cycles and clears on every state entry.
- IDLE:
  - Condition: `Req` ≠ 0.
  - Winner w is the first set bit searched from `last`+1 upward, modulo N_REQ.
  - Next edge: `Grant[w]`=1 for one cycle, `TxData` ← `ReqData[w]`, `TxSend` ← 1, `last` ← w, go to SEND.
- SEND: on the tick that makes `tcnt` = SEND_HOLD, `TxSend` ← 0 and go to FRAME.
- FRAME: on the tick that makes `tcnt` = FRAME_TICKS, go to GAP, or straight to IDLE if GAP_TICKS = 0.
- GAP: on the tick that makes `tcnt` = GAP_TICKS, go to IDLE.
- Requester protocol:
  - Hold `Req` with stable `ReqData` until `Grant`.
  - In the cycle after `Grant`, the requester either drops `Req` or presents its next byte.
  - Dropping `Req` before it is granted is legal; nothing is sent.
- `Req` is sampled only in IDLE. Requests arriving in SEND, FRAME or GAP wait; none are lost while held.
- Simultaneous requests: at most one grant per frame, in round-robin order.
- `TxData` holds its value from grant until the next grant.
- Reset values:
  - state = IDLE; `Grant` = 0; `TxSend` = 0; `TxData` = 8'h00; `Busy` = 0.
  - `last` = N_REQ-1, so requester 0 has first priority.
  - Divider and `tcnt` = 0.
- Reset mid-operation:
  - Everything returns to reset values on the next edge and `TxSend` drops immediately.
  - The partially sent frame is abandoned. Re-synchronising the transmitter is the RS232 block's own Reset.

## Timing
- Grant latency: 1 cycle from `Req` being seen in IDLE to `Grant`, `TxSend` and `TxData` valid together.
- `TxSend` high time: SEND_HOLD ticks. In cycles this is between (SEND_HOLD-1)·DIV+1 and SEND_HOLD·DIV, because the divider phase is free.
- Grant-to-grant minimum: (SEND_HOLD + FRAME_TICKS + GAP_TICKS) ticks + 1 cycle.
- `Busy` rises in the same cycle as `Grant` and falls on the IDLE entry edge.
- A request pending at that edge is granted on the following edge.
- Counter widths:
  - `tcnt` is sized as clog2 of max(SEND_HOLD, FRAME_TICKS, GAP_TICKS)+1.
  - The divider counter is sized as clog2(DIV).
  - No counter wraps within a state.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum (IDLE, SEND, FRAME, GAP);
  - the default constants DIV_DEFAULT = 326, FRAME_TICKS_DEFAULT = 160, SEND_HOLD_DEFAULT = 2, GAP_TICKS_DEFAULT = 16.
- Sub-module `tick_divider` (parameter DIV; ports SystemClock, Reset, Tick) contains the free-running divider.
- Arbiter and FSM stay in the top module.

## Test plan
Bench parameters: DIV=4, SEND_HOLD=2, FRAME_TICKS=10, GAP_TICKS=2, N_REQ=4.
1. Reset check: assert `Reset` for 3 cycles with `Req`=4'b1111. All outputs must be 0 during reset. One cycle after release, `Grant`=4'b0001 and `TxData`=`ReqData[7:0]`.
2. Single request: requester 2 sends 8'hA5. Expect:
   - `Grant`=4'b0100 for exactly one cycle, `TxData`=8'hA5;
   - `TxSend` high for 2 ticks (5–8 cycles);
   - `Busy` high for 14 ticks, then low.
3. Round-robin: hold `Req`=4'b1111 continuously. Grants must be exactly 0,1,2,3,0 with grant-to-grant spacing ≥ 14 ticks.
4. Fairness under a late request: `Req`=4'b0001 always, and requester 3 raises `Req` during FRAME. The next grant must be to requester 3, then to requester 0.
5. Withdrawn request: requester 1 raises then drops `Req` while `Busy`. No grant to requester 1 and no extra `TxSend`.
6. Reset mid-FRAME: assert `Reset` at tick 5 of FRAME. `TxSend`=0 and `Busy`=0 on the next edge. A later `Req`=4'b0010 is granted 1 cycle after reset release.
